// File: rtl/pipeline_sink.sv
// ----------------------------------------------------------------------------
// Module   : pipeline_sink
// Brief    : Consumer endpoint for the address pipeline. Buffers address/id
//            beats in a small FIFO under stall backpressure, discards beats
//            killed by a per-ID flush, hands the rest to a valid/ready
//            consumer and flags out-of-order IDs.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module pipeline_sink #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int ID_WIDTH      = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDRESS_WIDTH-1:0]      pipe_address,
  input  logic [ID_WIDTH-1:0]           pipe_id,
  input  logic                          pipe_valid,
  output logic                          pipe_stall,
  input  logic                          flush,
  input  logic [ID_WIDTH-1:0]           flush_id,
  output logic [ADDRESS_WIDTH-1:0]      cons_address,
  output logic [ID_WIDTH-1:0]           cons_id,
  output logic                          cons_valid,
  input  logic                          cons_ready,
  output logic                          seq_error,
  output logic [7:0]                    err_count,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

  localparam int                 C_PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [C_PTR_W:0]   C_FULL  = (C_PTR_W+1)'(FIFO_DEPTH);

  // Entry storage, split into parallel arrays of {address, id, killed}
  logic [ADDRESS_WIDTH-1:0] r_addr   [FIFO_DEPTH];
  logic [ID_WIDTH-1:0]      r_id     [FIFO_DEPTH];
  logic                     r_killed [FIFO_DEPTH];

  logic [C_PTR_W-1:0]       r_head;
  logic [C_PTR_W-1:0]       r_tail;
  logic [C_PTR_W:0]         r_count;
  logic [ID_WIDTH-1:0]      r_exp_id;
  logic                     r_seq_error;
  logic [7:0]               r_err_count;

  logic w_not_empty;
  logic w_head_killed;
  logic w_accept;
  logic w_drop;
  logic w_push;
  logic w_handshake;
  logic w_pop;

  // Handshake qualifiers; stall depends on registered count only
  always_comb begin
    pipe_stall    = (r_count == C_FULL);
    w_not_empty   = (r_count != '0);
    w_head_killed = r_killed[r_head];
    cons_valid    = w_not_empty && !w_head_killed;
    cons_address  = r_addr[r_head];
    cons_id       = r_id[r_head];
    w_accept      = pipe_valid && !pipe_stall;
    w_drop        = flush && (flush_id == pipe_id);
    w_push        = w_accept && !w_drop;
    w_handshake   = cons_valid && cons_ready;
    // A killed head leaves on its own without ever being presented
    w_pop         = w_handshake || (w_not_empty && w_head_killed);
  end

  assign seq_error = r_seq_error;
  assign err_count = r_err_count;
  assign occupancy = r_count;

  // Entry storage: flush marks matching entries, push writes the tail slot.
  // Marking stale (non-live) slots is harmless since a push clears killed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_addr[i]   <= '0;
        r_id[i]     <= '0;
        r_killed[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        // The head completing its handshake this cycle is left alone
        if (flush && (r_id[i] == flush_id) &&
            !(w_handshake && (C_PTR_W'(i) == r_head))) begin
          r_killed[i] <= 1'b1;
        end
      end
      if (w_push) begin
        r_addr[r_tail]   <= pipe_address;
        r_id[r_tail]     <= pipe_id;
        r_killed[r_tail] <= 1'b0;
      end
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks net flow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Order checker: compare each stored beat to the expected ID, then resync
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_exp_id    <= '0;
      r_seq_error <= 1'b0;
      r_err_count <= '0;
    end else if (w_push) begin
      r_exp_id <= pipe_id + ID_WIDTH'(1);
      if (pipe_id != r_exp_id) begin
        r_seq_error <= 1'b1;
        if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_sink.sv
// ----------------------------------------------------------------------------
// Module   : tb_pipeline_sink
// Brief    : Scoreboard bench for pipeline_sink.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_sink;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] pipe_address = '0;
  logic [3:0] pipe_id = '0;
  logic       pipe_valid = 1'b0;
  logic       pipe_stall;
  logic       flush = 1'b0;
  logic [3:0] flush_id = '0;
  logic [7:0] cons_address;
  logic [3:0] cons_id;
  logic       cons_valid;
  logic       cons_ready = 1'b0;
  logic       seq_error;
  logic [7:0] err_count;
  logic [2:0] occupancy;

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] sb[$];   // {address, id}

  pipeline_sink #(.ADDRESS_WIDTH(8), .ID_WIDTH(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .pipe_address(pipe_address), .pipe_id(pipe_id), .pipe_valid(pipe_valid),
    .pipe_stall(pipe_stall), .flush(flush), .flush_id(flush_id),
    .cons_address(cons_address), .cons_id(cons_id), .cons_valid(cons_valid),
    .cons_ready(cons_ready), .seq_error(seq_error), .err_count(err_count),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] addr_of(input logic [3:0] id);
    return {id, 4'h0} ^ 8'h5A;
  endfunction

  // Every transfer seen at the consumer must match the scoreboard head
  always @(negedge clk) begin
    if (cons_valid && cons_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        logic [11:0] e;
        e = sb.pop_front();
        chk("cons_id", {28'd0, cons_id}, {28'd0, e[3:0]});
        chk("cons_address", {24'd0, cons_address}, {24'd0, e[11:4]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until the sink accepts it
  task automatic send(input logic [3:0] id);
    int n;
    n = 0;
    pipe_valid   = 1'b1;
    pipe_id      = id;
    pipe_address = addr_of(id);
    @(negedge clk);
    while (pipe_stall && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
    sb.push_back({addr_of(id), id});
    @(posedge clk);
    #1;
    pipe_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    sb.delete();
  endtask

  initial begin
    step();
    do_reset();
    chk("rst_stall", pipe_stall, 0);
    chk("rst_valid", cons_valid, 0);
    chk("rst_addr", cons_address, 0);
    chk("rst_id", cons_id, 0);
    chk("rst_seq", seq_error, 0);
    chk("rst_errcnt", err_count, 0);
    chk("rst_occ", occupancy, 0);

    // Streaming: each beat visible right after its accepting edge
    cons_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(4'(i));
      chk("stream_lat_valid", cons_valid, 1);
      chk("stream_lat_id", cons_id, i);
      chk("stream_stall", pipe_stall, 0);
    end
    drain();
    chk("stream_seq", seq_error, 0);

    // Backpressure: four beats fill the FIFO, fifth is held off
    do_reset();
    cons_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'(i));
    chk("bp_stall_full", pipe_stall, 1);
    chk("bp_occ_full", occupancy, 4);
    fork send(4'd4); join_none
    @(negedge clk);
    @(negedge clk);
    chk("bp_held_occ", occupancy, 4);
    chk("bp_held_stall", pipe_stall, 1);
    @(posedge clk);
    #1;
    cons_ready = 1'b1;
    step();
    chk("bp_occ_after_pop", occupancy, 3);
    chk("bp_stall_fall", pipe_stall, 0);
    drain();
    chk("bp_seq", seq_error, 0);

    // Flush mid-FIFO: kill ID 3 among 2,3,4
    do_reset();
    cons_ready = 1'b1;
    send(4'd0);
    send(4'd1);
    drain();
    cons_ready = 1'b0;
    send(4'd2);
    send(4'd3);
    send(4'd4);
    flush    = 1'b1;
    flush_id = 4'd3;
    foreach (sb[k]) if (sb[k][3:0] == 4'd3) sb.delete(k);
    step();
    flush = 1'b0;
    chk("fl_occ_killed_kept", occupancy, 3);
    chk("fl_head_id", cons_id, 2);
    cons_ready = 1'b1;
    step();
    chk("fl_bubble", cons_valid, 0);
    step();
    chk("fl_after_valid", cons_valid, 1);
    chk("fl_after_id", cons_id, 4);
    drain();
    chk("fl_errcnt", err_count, 0);

    // Flush on arrival: ID 5 dropped, then ID 5 accepted without error
    pipe_valid   = 1'b1;
    pipe_id      = 4'd5;
    pipe_address = 8'hEE;
    flush        = 1'b1;
    flush_id     = 4'd5;
    step();
    pipe_valid = 1'b0;
    flush      = 1'b0;
    chk("arr_occ", occupancy, 0);
    chk("arr_valid", cons_valid, 0);
    send(4'd5);
    drain();
    chk("arr_errcnt", err_count, 0);
    chk("arr_seq", seq_error, 0);

    // Order error: 0,1,3 flags once; 4 resyncs cleanly
    do_reset();
    send(4'd0);
    send(4'd1);
    send(4'd3);
    chk("ord_seq", seq_error, 1);
    chk("ord_cnt", err_count, 1);
    send(4'd4);
    chk("ord_cnt_hold", err_count, 1);
    drain();

    // ID wrap across 15->0 and pointer wrap across many pushes
    do_reset();
    for (int i = 0; i < 18; i++) send(4'(i));
    drain();
    chk("wrap_seq", seq_error, 0);
    chk("wrap_cnt", err_count, 0);

    // Asynchronous reset with three entries stored
    cons_ready = 1'b0;
    send(4'd2);
    send(4'd3);
    send(4'd4);
    chk("ar_occ_before", occupancy, 3);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_occ", occupancy, 0);
    chk("ar_valid", cons_valid, 0);
    chk("ar_stall", pipe_stall, 0);
    #1;
    reset = 1'b0;
    sb.delete();
    step();
    chk("ar_occ_after", occupancy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
